// File: rtl/ddr3_arb_pkg.sv
// Shared types for the DDR3 command arbiter: command encodings, burst width, order-FIFO entry.
// Order entries carry the requester id and burst length of each outstanding read.
package ddr3_arb_pkg;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;
  localparam int   BURST_W   = 6;
  localparam int   ORD_ID_W  = 2;

  typedef struct packed {
    logic [ORD_ID_W-1:0] id;
    logic [BURST_W-1:0]  len;
  } ord_entry_t;

  localparam int ORD_W = $bits(ord_entry_t);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_WBURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ddr3_arb_order_fifo.sv
// Outstanding-read order FIFO: records {id, len} per issued read, head drives response routing.
// Latency: push visible at head next cycle. Backpressure: full/empty flags; push ignored when full.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ddr3_arb_order_fifo
  import ddr3_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ORD_W-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [ORD_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [ORD_W-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Shares one bridge cmd/rsp port among NREQ requesters; round-robin (or DDR3_ARB_FIXED_PRIO_EN fixed prio).
// Latency: zero-cycle combinational cmd and rsp muxes. Backpressure: ready passed through to the granted
// requester; reads stall while the order FIFO is full; write bursts hold the grant until the last beat.
module ddr3_cmd_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int OT_DEPTH = 4,
  parameter int AW       = 27,
  parameter int DW       = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        s_cmd_valid,
  output logic [NREQ-1:0]        s_cmd_ready,
  input  logic [NREQ-1:0]        s_cmd_type,
  input  logic [NREQ*AW-1:0]     s_cmd_addr,
  input  logic [NREQ*BURST_W-1:0] s_cmd_burst,
  input  logic [NREQ*DW-1:0]     s_cmd_wdata,
  input  logic [NREQ*DW/8-1:0]   s_cmd_wmask,
  output logic [NREQ-1:0]        s_rsp_valid,
  input  logic [NREQ-1:0]        s_rsp_ready,
  output logic                   s_rsp_last,
  output logic [DW-1:0]          s_rsp_data,
  output logic                   m_cmd_valid,
  input  logic                   m_cmd_ready,
  output logic                   m_cmd_type,
  output logic [AW-1:0]          m_cmd_addr,
  output logic [BURST_W-1:0]     m_cmd_burst,
  output logic [DW-1:0]          m_cmd_wdata,
  output logic [DW/8-1:0]        m_cmd_wmask,
  input  logic                   m_rsp_valid,
  output logic                   m_rsp_ready,
  input  logic [DW-1:0]          m_rsp_data,
  output logic                   err_unexp_rsp
);

  localparam int PW = $clog2(NREQ);

  arb_state_t         state, state_nxt;
  logic [PW-1:0]      rr_ptr, lock, gnt, pick;
  logic               pick_vld, gnt_vld, cmd_hs, rsp_hs;
  logic [BURST_W-1:0] wcnt, rcnt;
  logic [NREQ-1:0]    elig;
  logic               ord_push, ord_pop, ord_full, ord_empty;
  logic [ORD_W-1:0]   ord_head_raw;
  ord_entry_t         ord_head, ord_in;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
  endfunction

  // Full is the registered flag: a same-cycle pop never admits a new read.
  always_comb begin
    for (int i = 0; i < NREQ; i++)
      elig[i] = s_cmd_valid[i] && ((s_cmd_type[i] == CMD_WRITE) || !ord_full);
  end

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
`ifdef DDR3_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick     = PW'(i);
        pick_vld = 1'b1;
      end
    end
`else
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr) + k) % NREQ]) begin
        pick     = PW'((int'(rr_ptr) + k) % NREQ);
        pick_vld = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cmd_hs && m_cmd_type == CMD_WRITE && m_cmd_burst != '0) state_nxt = ST_WBURST;
      ST_WBURST: if (cmd_hs && wcnt == BURST_W'(1)) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // During a burst only writes from the locked requester are presented.
  always_comb begin
    gnt     = pick;
    gnt_vld = pick_vld;
    if (state == ST_WBURST) begin
      gnt     = lock;
      gnt_vld = s_cmd_valid[lock] && (s_cmd_type[lock] == CMD_WRITE);
    end
    if (rst) gnt_vld = 1'b0;
  end

  always_comb begin
    s_cmd_ready      = '0;
    s_cmd_ready[gnt] = gnt_vld && m_cmd_ready;
  end

  assign m_cmd_valid = gnt_vld;
  assign m_cmd_type  = s_cmd_type[gnt];
  assign m_cmd_addr  = s_cmd_addr[int'(gnt)*AW +: AW];
  assign m_cmd_burst = s_cmd_burst[int'(gnt)*BURST_W +: BURST_W];
  assign m_cmd_wdata = s_cmd_wdata[int'(gnt)*DW +: DW];
  assign m_cmd_wmask = s_cmd_wmask[int'(gnt)*(DW/8) +: DW/8];
  assign cmd_hs      = gnt_vld && m_cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      lock   <= '0;
      wcnt   <= '0;
    end else if (cmd_hs) begin
      if (state == ST_IDLE) begin
        if (m_cmd_type == CMD_READ || m_cmd_burst == '0) begin
          rr_ptr <= ptr_inc(gnt);
        end else begin
          lock <= gnt;
          wcnt <= m_cmd_burst;
        end
      end else begin
        wcnt <= wcnt - 1'b1;
        if (wcnt == BURST_W'(1)) rr_ptr <= ptr_inc(lock);
      end
    end
  end

  assign ord_push = cmd_hs && (state == ST_IDLE) && (m_cmd_type == CMD_READ);
  assign ord_in   = '{id: ORD_ID_W'(gnt), len: m_cmd_burst};
  assign ord_head = ord_entry_t'(ord_head_raw);

  ddr3_arb_order_fifo #(.DEPTH(OT_DEPTH)) u_order_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (ord_push),
    .push_dat (ord_in),
    .pop      (ord_pop),
    .full     (ord_full),
    .empty    (ord_empty),
    .head     (ord_head_raw)
  );

  // With nothing outstanding, stray beats are accepted and dropped.
  always_comb begin
    s_rsp_valid = '0;
    m_rsp_ready = 1'b0;
    if (!rst) begin
      if (ord_empty) begin
        m_rsp_ready = m_rsp_valid;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (ord_head.id == ORD_ID_W'(i)) begin
            s_rsp_valid[i] = m_rsp_valid;
            m_rsp_ready    = s_rsp_ready[i];
          end
        end
      end
    end
  end

  assign s_rsp_last = !rst && !ord_empty && (rcnt == ord_head.len);
  assign s_rsp_data = m_rsp_data;
  assign rsp_hs     = m_rsp_valid && m_rsp_ready && !ord_empty;
  assign ord_pop    = rsp_hs && s_rsp_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt          <= '0;
      err_unexp_rsp <= 1'b0;
    end else begin
      if (ord_pop)     rcnt <= '0;
      else if (rsp_hs) rcnt <= rcnt + 1'b1;
      if (ord_empty && m_rsp_valid) err_unexp_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Directed bench for ddr3_cmd_arbiter: grant order, write lock, read routing, FIFO full, stray rsp, reset.
module tb_ddr3_cmd_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 27;
  localparam int DW   = 128;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     s_cmd_valid, s_cmd_ready, s_cmd_type;
  logic [NREQ*AW-1:0]  s_cmd_addr;
  logic [NREQ*6-1:0]   s_cmd_burst;
  logic [NREQ*DW-1:0]  s_cmd_wdata;
  logic [NREQ*DW/8-1:0] s_cmd_wmask;
  logic [NREQ-1:0]     s_rsp_valid, s_rsp_ready;
  logic                s_rsp_last;
  logic [DW-1:0]       s_rsp_data;
  logic                m_cmd_valid, m_cmd_ready, m_cmd_type;
  logic [AW-1:0]       m_cmd_addr;
  logic [5:0]          m_cmd_burst;
  logic [DW-1:0]       m_cmd_wdata;
  logic [DW/8-1:0]     m_cmd_wmask;
  logic                m_rsp_valid, m_rsp_ready;
  logic [DW-1:0]       m_rsp_data;
  logic                err_unexp_rsp;

  int n_vec  = 0;
  int n_miss = 0;

  logic [1:0] t1_gnt [4];
  logic [1:0] t3_vld [6];
  logic       t3_last[6];

  ddr3_cmd_arbiter #(.NREQ(NREQ), .OT_DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_type(s_cmd_type),
    .s_cmd_addr(s_cmd_addr), .s_cmd_burst(s_cmd_burst), .s_cmd_wdata(s_cmd_wdata),
    .s_cmd_wmask(s_cmd_wmask), .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
    .s_rsp_last(s_rsp_last), .s_rsp_data(s_rsp_data),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_type(m_cmd_type),
    .m_cmd_addr(m_cmd_addr), .m_cmd_burst(m_cmd_burst), .m_cmd_wdata(m_cmd_wdata),
    .m_cmd_wmask(m_cmd_wmask), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_data(m_rsp_data), .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic v, input logic typ,
                         input logic [AW-1:0] addr, input logic [5:0] burst);
    s_cmd_valid[r]            = v;
    s_cmd_type[r]             = typ;
    s_cmd_addr[r*AW +: AW]    = addr;
    s_cmd_burst[r*6 +: 6]     = burst;
    s_cmd_wdata[r*DW +: DW]   = DW'(addr);
    s_cmd_wmask[r*DW/8 +: DW/8] = '0;
  endtask

  task automatic idle_inputs();
    s_cmd_valid = '0; s_cmd_type = '0; s_cmd_addr = '0; s_cmd_burst = '0;
    s_cmd_wdata = '0; s_cmd_wmask = '0; s_rsp_ready = '0;
    m_cmd_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = '0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, {s_cmd_ready, m_cmd_valid, s_rsp_valid, m_rsp_ready, s_rsp_last, err_unexp_rsp}, '0);
  endtask

  initial begin
`ifdef DDR3_ARB_FIXED_PRIO_EN
    t1_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    t1_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    t3_vld  = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01};
    t3_last = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    chk_reset_outs("rst_held");
    rst = 1'b0;
    #2 chk_reset_outs("rst_release");
    tick();

    // 1: both requesters stream single-beat reads
    set_cmd(0, 1, 1, 27'h100, 0);
    set_cmd(1, 1, 1, 27'h200, 0);
    m_cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("t1_grant", s_cmd_ready, t1_gnt[k]);
      chk("t1_addr", m_cmd_addr, (t1_gnt[k] == 2'b01) ? 27'h100 : 27'h200);
      tick();
    end
    #2 chk("t1_full_block", {m_cmd_valid, s_cmd_ready}, 3'b000);
    s_cmd_valid = '0; m_cmd_ready = 1'b0;
    m_rsp_valid = 1'b1; s_rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("t1_rsp_route", s_rsp_valid, t1_gnt[k]);
      chk("t1_rsp_last", s_rsp_last, 1'b1);
      tick();
    end
    m_rsp_valid = 1'b0;

    // 2: req1 write burst of 4 locks out req0
    set_cmd(1, 1, 0, 27'h300, 3);
    m_cmd_ready = 1'b1;
    #2 chk("t2_first", s_cmd_ready, 2'b10);
    chk("t2_burst", m_cmd_burst, 6'd3);
    tick();
    set_cmd(0, 1, 0, 27'h400, 0);
    m_cmd_ready = 1'b0;
    #2 chk("t2_hold", {m_cmd_valid, s_cmd_ready}, 3'b100);
    chk("t2_lock_addr", m_cmd_addr, 27'h300);
    tick();
    m_cmd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2 chk("t2_beat", s_cmd_ready, 2'b10);
      tick();
    end
    #2 chk("t2_release", s_cmd_ready, 2'b01);
    chk("t2_release_addr", m_cmd_addr, 27'h400);
    tick();
    s_cmd_valid = '0;

    // 3: mixed-length reads routed back in issue order
    set_cmd(0, 1, 1, 27'h500, 1);
    #2 chk("t3_iss0", s_cmd_ready, 2'b01);
    tick();
    set_cmd(0, 0, 1, 27'h500, 1);
    set_cmd(1, 1, 1, 27'h600, 0);
    #2 chk("t3_iss1", s_cmd_ready, 2'b10);
    tick();
    set_cmd(1, 0, 1, 27'h600, 0);
    set_cmd(0, 1, 1, 27'h700, 2);
    #2 chk("t3_iss2", s_cmd_ready, 2'b01);
    tick();
    s_cmd_valid = '0;
    m_rsp_valid = 1'b1; s_rsp_ready = 2'b10; m_rsp_data = 128'hC0;
    #2 chk("t3_backpress", {s_rsp_valid, m_rsp_ready}, 3'b010);
    tick();
    s_rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      m_rsp_data = 128'hD0 + 128'(k);
      #2;
      chk("t3_route", s_rsp_valid, t3_vld[k]);
      chk("t3_last", s_rsp_last, t3_last[k]);
      chk("t3_data", s_rsp_data, 128'hD0 + 128'(k));
      tick();
    end
    m_rsp_valid = 1'b0;

    // 4: order FIFO full stalls reads but not writes
    set_cmd(0, 1, 1, 27'h800, 0);
    for (int k = 0; k < 4; k++) begin
      #2 chk("t4_fill", s_cmd_ready, 2'b01);
      tick();
    end
    set_cmd(1, 1, 0, 27'h900, 0);
    #2 chk("t4_write_pass", s_cmd_ready, 2'b10);
    chk("t4_write_type", m_cmd_type, 1'b0);
    tick();
    set_cmd(1, 0, 0, 27'h900, 0);
    m_rsp_valid = 1'b1; s_rsp_ready = 2'b01;
    #2 chk("t4_stall_on_pop", {m_cmd_valid, s_cmd_ready}, 3'b000);
    chk("t4_pop_ready", m_rsp_ready, 1'b1);
    tick();
    m_rsp_valid = 1'b0;
    #2 chk("t4_unblock", s_cmd_ready, 2'b01);
    tick();
    s_cmd_valid = '0;
    m_rsp_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2 chk("t4_drain", {s_rsp_valid, s_rsp_last}, 3'b011);
      tick();
    end

    // 5: response with nothing outstanding
    #2 chk("t5_drain_ready", m_rsp_ready, 1'b1);
    chk("t5_no_route", s_rsp_valid, 2'b00);
    chk("t5_err_before", err_unexp_rsp, 1'b0);
    tick();
    m_rsp_valid = 1'b0;
    #2 chk("t5_err_sticky", err_unexp_rsp, 1'b1);
    tick();
    #2 chk("t5_err_stays", err_unexp_rsp, 1'b1);

    // 6: reset mid-burst with reads outstanding
    set_cmd(0, 1, 1, 27'hA00, 0);
    #2 chk("t6_rd0", s_cmd_ready, 2'b01);
    tick();
    set_cmd(0, 0, 1, 27'hA00, 0);
    set_cmd(1, 1, 1, 27'hB00, 0);
    #2 chk("t6_rd1", s_cmd_ready, 2'b10);
    tick();
    set_cmd(1, 0, 1, 27'hB00, 0);
    set_cmd(0, 1, 0, 27'hC00, 3);
    #2 chk("t6_wr_first", s_cmd_ready, 2'b01);
    tick();
    #2 chk("t6_wr_second", s_cmd_ready, 2'b01);
    tick();
    rst = 1'b1;
    s_cmd_valid = '0;
    tick();
    rst = 1'b0;
    #2 chk_reset_outs("t6_after_rst");
    set_cmd(1, 1, 0, 27'hD00, 0);
    #2 chk("t6_no_lock", s_cmd_ready, 2'b10);
    tick();
    set_cmd(1, 0, 0, 27'hD00, 0);
    set_cmd(0, 1, 1, 27'hE00, 1);
    #2 chk("t6_fresh_rd", s_cmd_ready, 2'b01);
    tick();
    s_cmd_valid = '0;
    m_rsp_valid = 1'b1; s_rsp_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      #2 chk("t6_rsp_route", s_rsp_valid, 2'b01);
      chk("t6_rsp_last", s_rsp_last, (k == 1));
      tick();
    end
    m_rsp_valid = 1'b0;
    #2 chk("t6_err_clear", err_unexp_rsp, 1'b0);
    chk("t6_idle_ready", m_rsp_ready, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
